// File: rtl/div_sqrt_arbiter_mvp.sv
// Round-robin front end that shares one iterative div/sqrt unit between NUM_REQ requesters.
// Optional perf counters (Perf_ops_DO, Perf_cycles_DO) are built when DIV_SQRT_ARB_PERF_CNT_EN is defined.
module div_sqrt_arbiter_mvp #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned C_PC        = 6,
  parameter int unsigned C_MANT_FP64 = 52,
  parameter int unsigned C_EXP_FP64  = 11
) (
  input  logic                                Clk_CI,
  input  logic                                Rst_RBI,
  input  logic [NUM_REQ-1:0]                  Req_valid_SI,
  output logic [NUM_REQ-1:0]                  Req_ready_SO,
  input  logic [NUM_REQ-1:0]                  Req_sqrt_SI,
  input  logic [2*NUM_REQ-1:0]                Req_fmt_SI,
  input  logic [C_PC*NUM_REQ-1:0]             Req_prec_SI,
  input  logic [(C_MANT_FP64+1)*NUM_REQ-1:0]  Req_mant_a_DI,
  input  logic [(C_MANT_FP64+1)*NUM_REQ-1:0]  Req_mant_b_DI,
  input  logic [(C_EXP_FP64+1)*NUM_REQ-1:0]   Req_exp_a_DI,
  input  logic [(C_EXP_FP64+1)*NUM_REQ-1:0]   Req_exp_b_DI,
  input  logic [NUM_REQ-1:0]                  Req_kill_SI,
  output logic                                Div_start_SO,
  output logic                                Sqrt_start_SO,
  output logic                                Start_SO,
  output logic                                Kill_SO,
  output logic [C_PC-1:0]                     Precision_ctl_SO,
  output logic [1:0]                          Format_sel_SO,
  output logic [C_MANT_FP64:0]                Mant_a_DO,
  output logic [C_MANT_FP64:0]                Mant_b_DO,
  output logic [C_EXP_FP64:0]                 Exp_a_DO,
  output logic [C_EXP_FP64:0]                 Exp_b_DO,
  input  logic                                Unit_ready_SI,
  input  logic                                Unit_done_SI,
  input  logic [C_MANT_FP64+4:0]              Mant_z_DI,
  input  logic [C_EXP_FP64+1:0]               Exp_z_DI,
  output logic                                Rsp_valid_SO,
  input  logic                                Rsp_ready_SI,
  output logic [ID_W-1:0]                     Rsp_id_SO,
  output logic [C_MANT_FP64+4:0]              Rsp_mant_DO,
  output logic [C_EXP_FP64+1:0]               Rsp_exp_DO,
  output logic                                Busy_SO
`ifdef DIV_SQRT_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                         Perf_ops_DO,
  output logic [15:0]                         Perf_cycles_DO
`endif
);

  localparam int unsigned MW  = C_MANT_FP64 + 1;
  localparam int unsigned EW  = C_EXP_FP64 + 1;
  localparam int unsigned ZMW = C_MANT_FP64 + 5;
  localparam int unsigned ZEW = C_EXP_FP64 + 2;

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_owner;
  logic              r_sqrt;
  logic [1:0]        r_fmt;
  logic [C_PC-1:0]   r_prec;
  logic [MW-1:0]     r_mant_a;
  logic [MW-1:0]     r_mant_b;
  logic [EW-1:0]     r_exp_a;
  logic [EW-1:0]     r_exp_b;
  logic [ZMW-1:0]    r_rsp_mant;
  logic [ZEW-1:0]    r_rsp_exp;

  logic              w_any_valid;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_idx;
  logic              w_grant;
  logic              w_owner_kill;
  logic [ID_W-1:0]   w_ptr_after_owner;

  // Scan offsets from high to low so the lowest offset from the pointer wins.
  always_comb begin
    w_any_valid = 1'b0;
    w_winner    = '0;
    w_idx       = '0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      w_idx = ID_W'((int'(r_ptr) + off) % int'(NUM_REQ));
      if (Req_valid_SI[w_idx]) begin
        w_any_valid = 1'b1;
        w_winner    = w_idx;
      end
    end
  end

  assign w_grant           = (r_state == StIdle) && w_any_valid && Unit_ready_SI;
  assign w_owner_kill      = Req_kill_SI[r_owner];
  assign w_ptr_after_owner = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_grant) w_state_next = StIssue;
      StIssue: w_state_next = w_owner_kill ? StIdle : StBusy;
      StBusy: begin
        if (w_owner_kill) begin
          w_state_next = StIdle;
        end else if (Unit_done_SI) begin
          w_state_next = StResp;
        end
      end
      StResp:  if (w_owner_kill || Rsp_ready_SI) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    Req_ready_SO  = '0;
    Start_SO      = 1'b0;
    Div_start_SO  = 1'b0;
    Sqrt_start_SO = 1'b0;
    Kill_SO       = 1'b0;
    Rsp_valid_SO  = 1'b0;
    unique case (r_state)
      StIdle: if (w_grant && Rst_RBI) Req_ready_SO[w_winner] = 1'b1;
      StIssue: begin
        if (w_owner_kill) begin
          Kill_SO = 1'b1;
        end else begin
          Start_SO      = 1'b1;
          Div_start_SO  = ~r_sqrt;
          Sqrt_start_SO = r_sqrt;
        end
      end
      StBusy:  Kill_SO = w_owner_kill;
      StResp:  Rsp_valid_SO = ~w_owner_kill;
      default: ;
    endcase
    Busy_SO = (r_state != StIdle);
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_sqrt     <= 1'b0;
      r_fmt      <= '0;
      r_prec     <= '0;
      r_mant_a   <= '0;
      r_mant_b   <= '0;
      r_exp_a    <= '0;
      r_exp_b    <= '0;
      r_rsp_mant <= '0;
      r_rsp_exp  <= '0;
    end else begin
      if (w_grant) begin
        r_owner  <= w_winner;
        r_sqrt   <= Req_sqrt_SI[w_winner];
        r_fmt    <= Req_fmt_SI[int'(w_winner)*2 +: 2];
        r_prec   <= Req_prec_SI[int'(w_winner)*C_PC +: C_PC];
        r_mant_a <= Req_mant_a_DI[int'(w_winner)*MW +: MW];
        r_mant_b <= Req_mant_b_DI[int'(w_winner)*MW +: MW];
        r_exp_a  <= Req_exp_a_DI[int'(w_winner)*EW +: EW];
        r_exp_b  <= Req_exp_b_DI[int'(w_winner)*EW +: EW];
      end
      if (r_state == StBusy && Unit_done_SI && !w_owner_kill) begin
        r_rsp_mant <= Mant_z_DI;
        r_rsp_exp  <= Exp_z_DI;
      end
      // Any exit back to idle (handshake or kill) hands priority to the next requester.
      if (r_state != StIdle && w_state_next == StIdle) begin
        r_ptr <= w_ptr_after_owner;
      end
    end
  end

  assign Precision_ctl_SO = r_prec;
  assign Format_sel_SO    = r_fmt;
  assign Mant_a_DO        = r_mant_a;
  assign Mant_b_DO        = r_mant_b;
  assign Exp_a_DO         = r_exp_a;
  assign Exp_b_DO         = r_exp_b;
  assign Rsp_id_SO        = r_owner;
  assign Rsp_mant_DO      = r_rsp_mant;
  assign Rsp_exp_DO       = r_rsp_exp;

`ifdef DIV_SQRT_ARB_PERF_CNT_EN
  logic [31:0] r_perf_ops;
  logic [15:0] r_perf_cycles;

  // Cycle count restarts at ISSUE and runs through the Done cycle, saturating.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_perf_ops    <= '0;
      r_perf_cycles <= '0;
    end else begin
      if (r_state == StResp && Rsp_ready_SI && !w_owner_kill) begin
        r_perf_ops <= r_perf_ops + 32'd1;
      end
      if (r_state == StIssue) begin
        r_perf_cycles <= 16'd1;
      end else if (r_state == StBusy && r_perf_cycles != 16'hFFFF) begin
        r_perf_cycles <= r_perf_cycles + 16'd1;
      end
    end
  end

  assign Perf_ops_DO    = r_perf_ops;
  assign Perf_cycles_DO = r_perf_cycles;
`endif

endmodule

// File: tb/tb_div_sqrt_arbiter_mvp.sv
// Self-checking bench for div_sqrt_arbiter_mvp (NUM_REQ=2, FP64 widths) with a fake div/sqrt unit.
`timescale 1ns/1ps
module tb_div_sqrt_arbiter_mvp;
  localparam int NR   = 2;
  localparam int ID_W = 1;
  localparam int PC   = 6;
  localparam int MW   = 53;
  localparam int EW   = 12;
  localparam int ZMW  = 57;
  localparam int ZEW  = 13;
  localparam int OPW  = PC + 2 + 2*MW + 2*EW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_sqrt, req_kill;
  logic [2*NR-1:0]   req_fmt;
  logic [PC*NR-1:0]  req_prec;
  logic [MW*NR-1:0]  req_mant_a, req_mant_b;
  logic [EW*NR-1:0]  req_exp_a, req_exp_b;
  logic              div_start, sqrt_start, start, kill;
  logic [PC-1:0]     prec_o;
  logic [1:0]        fmt_o;
  logic [MW-1:0]     mant_a_o, mant_b_o;
  logic [EW-1:0]     exp_a_o, exp_b_o;
  logic              unit_ready, unit_done;
  logic [ZMW-1:0]    mant_z;
  logic [ZEW-1:0]    exp_z;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [ZMW-1:0]    rsp_mant;
  logic [ZEW-1:0]    rsp_exp;
  logic              busy;
`ifdef DIV_SQRT_ARB_PERF_CNT_EN
  logic [31:0]       perf_ops;
  logic [15:0]       perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  logic [OPW-1:0] e_ops;
  logic           e_sqrt;

  div_sqrt_arbiter_mvp dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .Req_valid_SI(req_valid), .Req_ready_SO(req_ready), .Req_sqrt_SI(req_sqrt),
    .Req_fmt_SI(req_fmt), .Req_prec_SI(req_prec),
    .Req_mant_a_DI(req_mant_a), .Req_mant_b_DI(req_mant_b),
    .Req_exp_a_DI(req_exp_a), .Req_exp_b_DI(req_exp_b), .Req_kill_SI(req_kill),
    .Div_start_SO(div_start), .Sqrt_start_SO(sqrt_start), .Start_SO(start), .Kill_SO(kill),
    .Precision_ctl_SO(prec_o), .Format_sel_SO(fmt_o),
    .Mant_a_DO(mant_a_o), .Mant_b_DO(mant_b_o), .Exp_a_DO(exp_a_o), .Exp_b_DO(exp_b_o),
    .Unit_ready_SI(unit_ready), .Unit_done_SI(unit_done), .Mant_z_DI(mant_z), .Exp_z_DI(exp_z),
    .Rsp_valid_SO(rsp_valid), .Rsp_ready_SI(rsp_ready), .Rsp_id_SO(rsp_id),
    .Rsp_mant_DO(rsp_mant), .Rsp_exp_DO(rsp_exp), .Busy_SO(busy)
`ifdef DIV_SQRT_ARB_PERF_CNT_EN
    , .Perf_ops_DO(perf_ops), .Perf_cycles_DO(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arbitration rule: first valid index at or after the pointer, wrapping.
  function automatic int model_winner(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int w);
    logic [NR-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic rand_ops();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_mant_a = r[MW*NR-1:0];
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_mant_b = r[MW*NR-1:0];
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_exp_a = r[EW*NR-1:0];
    req_exp_b = r[2*EW*NR-1:EW*NR];
    req_prec  = r[100 +: PC*NR];
    req_fmt   = r[120 +: 2*NR];
    req_sqrt  = r[124 +: NR];
  endtask

  task automatic rand_z(output logic [ZMW-1:0] zm, output logic [ZEW-1:0] ze);
    logic [63:0] r;
    r  = {$urandom(), $urandom()};
    zm = r[ZMW-1:0];
    ze = r[63 -: ZEW];
  endtask

  task automatic snap(input int w);
    e_ops  = {req_prec[w*PC +: PC], req_fmt[w*2 +: 2], req_mant_a[w*MW +: MW],
              req_mant_b[w*MW +: MW], req_exp_a[w*EW +: EW], req_exp_b[w*EW +: EW]};
    e_sqrt = req_sqrt[w];
  endtask

  // Drives a granted operation through to its response handshake; called at the grant cycle.
  task automatic run_to_end(input int w);
    logic [ZMW-1:0] zm;
    logic [ZEW-1:0] ze;
    @(negedge clk); req_valid = '0;
    @(negedge clk); rand_z(zm, ze); mant_z = zm; exp_z = ze; unit_done = 1'b1;
    @(negedge clk); unit_done = 1'b0; rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    m_ptr = (w + 1) % NR;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_kill = '0; req_sqrt = '0; req_fmt = '0; req_prec = '0;
    req_mant_a = '0; req_mant_b = '0; req_exp_a = '0; req_exp_b = '0;
    unit_ready = 1'b1; unit_done = 1'b0; mant_z = '0; exp_z = '0; rsp_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({req_ready, start, div_start, sqrt_start, kill, rsp_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0",
               {req_ready, start, div_start, sqrt_start, kill, rsp_valid, busy});
    end
    checks++;
    if ({prec_o, fmt_o, mant_a_o, mant_b_o, exp_a_o, exp_b_o} !== '0) begin
      errors++;
      $display("FAIL reset_ops: got %h want 0", {prec_o, fmt_o, mant_a_o, mant_b_o, exp_a_o, exp_b_o});
    end
    checks++;
    if ({rsp_id, rsp_mant, rsp_exp} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got %h want 0", {rsp_id, rsp_mant, rsp_exp});
    end
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single_div();
    logic [ZMW-1:0] zm;
    logic [ZEW-1:0] ze;
    req_sqrt = '0; req_fmt = '0; req_prec = {NR{6'd53}};
    req_mant_a[MW-1:0] = {1'b1, 52'h8_0000_0000_0000};
    req_mant_b[MW-1:0] = {1'b1, 52'h4_0000_0000_0000};
    req_exp_a[EW-1:0]  = 12'd1023;
    req_exp_b[EW-1:0]  = 12'd1023;
    req_valid = 2'b01; #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL sd_grant: got %b want 01", req_ready);
    end
    snap(0);
    @(negedge clk); req_valid = '0; rand_ops(); #1;
    checks++;
    if ({start, div_start, sqrt_start, kill} !== 4'b1100) begin
      errors++; $display("FAIL sd_start: got %b want 1100", {start, div_start, sqrt_start, kill});
    end
    checks++;
    if ({prec_o, fmt_o, mant_a_o, mant_b_o, exp_a_o, exp_b_o} !== e_ops) begin
      errors++; $display("FAIL sd_operands: got %h want %h",
                         {prec_o, fmt_o, mant_a_o, mant_b_o, exp_a_o, exp_b_o}, e_ops);
    end
    @(negedge clk); #1;
    checks++;
    if ({start, busy} !== 2'b01) begin
      errors++; $display("FAIL sd_start_once: got start=%b busy=%b want 0/1", start, busy);
    end
    @(negedge clk);
    rand_z(zm, ze); mant_z = zm; exp_z = ze; unit_done = 1'b1; #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL sd_early_rsp: got %b want 0", rsp_valid);
    end
    @(negedge clk); unit_done = 1'b0; mant_z = ~zm; exp_z = ~ze; #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_mant, rsp_exp} !== {1'b1, 1'b0, zm, ze}) begin
      errors++; $display("FAIL sd_rsp: got %h want %h",
                         {rsp_valid, rsp_id, rsp_mant, rsp_exp}, {1'b1, 1'b0, zm, ze});
    end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0; #1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL sd_done: got valid=%b busy=%b want 0/0", rsp_valid, busy);
    end
    m_ptr = 1;
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; m_ptr = 0;
    for (int n = 0; n < 4; n++) begin
      int w;
      int dly;
      logic [ZMW-1:0] zm;
      logic [ZEW-1:0] ze;
      rand_ops(); req_valid = 2'b11; #1;
      w = model_winner(req_valid, m_ptr);
      checks++;
      if (req_ready !== onehot(w)) begin
        errors++; $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, onehot(w));
      end
      snap(w);
      @(negedge clk); rand_ops(); #1;
      checks++;
      if ({start, div_start, sqrt_start, req_ready} !== {1'b1, ~e_sqrt, e_sqrt, 2'b00} ||
          {prec_o, fmt_o, mant_a_o, mant_b_o, exp_a_o, exp_b_o} !== e_ops) begin
        errors++; $display("FAIL rr_issue%0d: got start=%b%b%b rdy=%b ops=%h want %b%b%b 00 %h",
                           n, start, div_start, sqrt_start, req_ready,
                           {prec_o, fmt_o, mant_a_o, mant_b_o, exp_a_o, exp_b_o},
                           1'b1, ~e_sqrt, e_sqrt, e_ops);
      end
      dly = $urandom_range(0, 3);
      repeat (dly + 1) @(negedge clk);
      rand_z(zm, ze); mant_z = zm; exp_z = ze; unit_done = 1'b1;
      @(negedge clk); unit_done = 1'b0; #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_mant, rsp_exp} !== {1'b1, ID_W'(w), zm, ze}) begin
        errors++; $display("FAIL rr_rsp%0d: got %h want %h", n,
                           {rsp_valid, rsp_id, rsp_mant, rsp_exp}, {1'b1, ID_W'(w), zm, ze});
      end
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0;
      m_ptr = (w + 1) % NR;
    end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    int w;
    logic [ZMW-1:0] zm;
    logic [ZEW-1:0] ze;
    rand_ops(); req_valid = 2'b01; #1;
    w = model_winner(req_valid, m_ptr);
    @(negedge clk); req_valid = 2'b10;
    @(negedge clk); rand_z(zm, ze); mant_z = zm; exp_z = ze; unit_done = 1'b1;
    @(negedge clk); unit_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mant_z = ~zm; #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_mant, rsp_exp, req_ready} !== {1'b1, ID_W'(w), zm, ze, 2'b00}) begin
        errors++; $display("FAIL bp_hold%0d: got %h want %h", i,
                           {rsp_valid, rsp_id, rsp_mant, rsp_exp, req_ready},
                           {1'b1, ID_W'(w), zm, ze, 2'b00});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1; #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL bp_no_grant_in_handshake: got %b want 00", req_ready);
    end
    @(negedge clk); rsp_ready = 1'b0; #1;
    m_ptr = (w + 1) % NR;
    w = model_winner(req_valid, m_ptr);
    checks++;
    if (req_ready !== onehot(w)) begin
      errors++; $display("FAIL bp_next_grant: got %b want %b", req_ready, onehot(w));
    end
    run_to_end(w);
  endtask

  task automatic test_kill_busy();
    int w;
    rand_ops(); req_valid = 2'b11; #1;
    w = model_winner(req_valid, m_ptr);
    @(negedge clk);
    @(negedge clk); req_kill = onehot(w); #1;
    checks++;
    if ({kill, start, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL kb_kill: got kill/start/valid=%b want 100", {kill, start, rsp_valid});
    end
    @(negedge clk); req_kill = '0; #1;
    m_ptr = (w + 1) % NR;
    w = model_winner(req_valid, m_ptr);
    checks++;
    if ({kill, rsp_valid, busy, req_ready} !== {3'b000, onehot(w)}) begin
      errors++; $display("FAIL kb_next: got %b want %b", {kill, rsp_valid, busy, req_ready},
                         {3'b000, onehot(w)});
    end
    run_to_end(w);
  endtask

  task automatic test_kill_issue_resp();
    int w;
    rand_ops(); req_valid = 2'b11; #1;
    w = model_winner(req_valid, m_ptr);
    @(negedge clk); req_kill = onehot(w); #1;
    checks++;
    if ({start, div_start, sqrt_start, kill} !== 4'b0001) begin
      errors++; $display("FAIL ki_pulse: got %b want 0001", {start, div_start, sqrt_start, kill});
    end
    @(negedge clk); req_kill = '0; #1;
    m_ptr = (w + 1) % NR;
    w = model_winner(req_valid, m_ptr);
    checks++;
    if ({busy, req_ready} !== {1'b0, onehot(w)}) begin
      errors++; $display("FAIL ki_next: got %b want %b", {busy, req_ready}, {1'b0, onehot(w)});
    end
    @(negedge clk); req_valid = '0;
    @(negedge clk); unit_done = 1'b1;
    @(negedge clk); unit_done = 1'b0; #1;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL kr_pre: got %b want 1", rsp_valid);
    end
    req_kill = onehot(w);
    @(negedge clk); req_kill = '0; #1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL kr_drop: got %b want 00", {rsp_valid, busy});
    end
    m_ptr = (w + 1) % NR;
  endtask

  task automatic test_kill_with_done();
    int w;
    rand_ops(); req_valid = 2'b11; #1;
    w = model_winner(req_valid, m_ptr);
    @(negedge clk); req_valid = '0;
    @(negedge clk); req_kill = onehot(w); unit_done = 1'b1; #1;
    checks++;
    if (kill !== 1'b1) begin
      errors++; $display("FAIL kd_kill: got %b want 1", kill);
    end
    @(negedge clk); req_kill = '0; unit_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({rsp_valid, busy, kill} !== 3'b000) begin
        errors++; $display("FAIL kd_no_rsp%0d: got %b want 000", i, {rsp_valid, busy, kill});
      end
      @(negedge clk);
    end
    m_ptr = (w + 1) % NR;
  endtask

  task automatic test_nonowner_kill();
    int w;
    logic [ZMW-1:0] zm;
    logic [ZEW-1:0] ze;
    rand_ops(); req_valid = 2'b11; #1;
    w = model_winner(req_valid, m_ptr);
    @(negedge clk); req_valid = '0; req_kill = onehot((w + 1) % NR); #1;
    checks++;
    if ({start, kill} !== 2'b10) begin
      errors++; $display("FAIL nk_issue: got start/kill=%b want 10", {start, kill});
    end
    @(negedge clk); #1;
    checks++;
    if ({kill, busy} !== 2'b01) begin
      errors++; $display("FAIL nk_busy: got kill/busy=%b want 01", {kill, busy});
    end
    rand_z(zm, ze); mant_z = zm; exp_z = ze; unit_done = 1'b1;
    @(negedge clk); unit_done = 1'b0; req_kill = '0; #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_mant, rsp_exp} !== {1'b1, ID_W'(w), zm, ze}) begin
      errors++; $display("FAIL nk_rsp: got %h want %h",
                         {rsp_valid, rsp_id, rsp_mant, rsp_exp}, {1'b1, ID_W'(w), zm, ze});
    end
    rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
    m_ptr = (w + 1) % NR;
  endtask

  task automatic test_unit_not_ready();
    int w;
    unit_done = 1'b1;
    @(negedge clk); unit_done = 1'b0; #1;
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL idle_done_ignored: got %b want 00", {busy, rsp_valid});
    end
    unit_ready = 1'b0; req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({req_ready, busy} !== 3'b000) begin
        errors++; $display("FAIL unr_no_grant%0d: got %b want 000", i, {req_ready, busy});
      end
      @(negedge clk);
    end
    unit_ready = 1'b1; #1;
    w = model_winner(req_valid, m_ptr);
    checks++;
    if (req_ready !== onehot(w)) begin
      errors++; $display("FAIL unr_grant: got %b want %b", req_ready, onehot(w));
    end
    run_to_end(w);
  endtask

  task automatic test_reset_busy();
    rand_ops(); req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++;
    if ({req_ready, start, div_start, sqrt_start, kill, rsp_valid, busy} !== '0 ||
        {prec_o, fmt_o, mant_a_o, mant_b_o, exp_a_o, exp_b_o, rsp_id, rsp_mant, rsp_exp} !== '0) begin
      errors++; $display("FAIL rb_outputs: ctrl=%b data=%h want 0",
                         {req_ready, start, div_start, sqrt_start, kill, rsp_valid, busy},
                         {prec_o, fmt_o, mant_a_o, mant_b_o, exp_a_o, exp_b_o, rsp_id, rsp_mant, rsp_exp});
    end
    @(negedge clk); rst_n = 1'b1; m_ptr = 0; #1;
    checks++;
    if (req_ready !== onehot(model_winner(req_valid, m_ptr))) begin
      errors++; $display("FAIL rb_ptr: got %b want %b", req_ready, onehot(model_winner(req_valid, m_ptr)));
    end
    run_to_end(model_winner(req_valid, m_ptr));
  endtask

  initial begin
    test_reset();
    test_single_div();
    test_round_robin();
    test_back_pressure();
    test_kill_busy();
    test_kill_issue_resp();
    test_kill_with_done();
    test_nonowner_kill();
    test_unit_not_ready();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
